// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// No logic; imported by the arbiter top and its round-robin picker.
// Bus geometry defaults live here so both files agree on lane count.
package mem_arbiter_pkg;

  localparam int WORD_W         = 32;
  localparam int ADDR_W         = 32;
  localparam int PROC_COUNT_DEF = 4;
  localparam int BUS_W_DEF      = 256;
  localparam int LANES          = BUS_W_DEF / WORD_W;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RD_WAIT,
    DONE
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin priority picker: first set request at or after ptr, wrapping.
// Purely combinational, zero latency.
// No backpressure; the caller decides when the pick is consumed.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  // Scan from ptr upward; the first hit wins and later hits are masked by any
  always_comb begin
    int j;
    j       = 0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any     = 1'b1;
        gnt_idx = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter muxing per-processor requests onto one data-memory port.
// Latency: write grant 2 cycles after request seen; read grant 2+L (L = memory latency).
// Backpressure: holds the memory request stable until i_mem_ready; one transaction outstanding.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int PROC_COUNT = PROC_COUNT_DEF,
  parameter int BUS_W      = BUS_W_DEF
) (
  input  logic                                  i_clk,
  input  logic                                  i_rstn,
  input  logic [PROC_COUNT-1:0]                 i_req_rd,
  input  logic [PROC_COUNT-1:0]                 i_req_wr,
  input  logic [PROC_COUNT-1:0]                 i_wr_en,
  input  logic [PROC_COUNT-1:0][ADDR_W-1:0]     i_addr,
  input  logic [PROC_COUNT-1:0][BUS_W-1:0]      i_wdata,
  input  logic [PROC_COUNT-1:0][2:0]            i_wr_size,
  output logic [PROC_COUNT-1:0]                 o_grant_rd,
  output logic [PROC_COUNT-1:0]                 o_grant_wr,
  output logic [BUS_W-1:0]                      o_rd_data,
  output logic                                  o_mem_req,
  output logic                                  o_mem_we,
  output logic [ADDR_W-1:0]                     o_mem_addr,
  output logic [BUS_W-1:0]                      o_mem_wdata,
  output logic [BUS_W/WORD_W-1:0]               o_mem_wmask,
  input  logic                                  i_mem_ready,
  input  logic [BUS_W-1:0]                      i_mem_rdata,
  input  logic                                  i_mem_rvalid,
  output logic                                  o_busy
);

  localparam int LANE_CNT = BUS_W / WORD_W;
  localparam int IDX_W    = (PROC_COUNT > 1) ? $clog2(PROC_COUNT) : 1;

  arb_state_t              state_q, state_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    op_wr_q, op_wr_d;
  addr_t                   addr_q, addr_d;
  logic [BUS_W-1:0]        wdata_q, wdata_d;
  logic [LANE_CNT-1:0]     wmask_q, wmask_d;
  logic [BUS_W-1:0]        rd_data_q, rd_data_d;
  logic                    mem_req_q, mem_req_d;
  logic                    busy_q, busy_d;
  logic [PROC_COUNT-1:0]   grant_rd_q, grant_rd_d;
  logic [PROC_COUNT-1:0]   grant_wr_q, grant_wr_d;

  logic [PROC_COUNT-1:0]   wr_vld;
  logic [PROC_COUNT-1:0]   req_vld;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_any;

  // A write request only counts when its enable is also high
  assign wr_vld  = i_req_wr & i_wr_en;
  assign req_vld = i_req_rd | wr_vld;

  rr_pick #(
    .N     (PROC_COUNT),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req     (req_vld),
    .ptr     (rr_ptr_q),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Next-state, transaction latch and registered-output decode
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    idx_d      = idx_q;
    op_wr_d    = op_wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    rd_data_d  = rd_data_q;
    grant_rd_d = '0;
    grant_wr_d = '0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          idx_d   = pick_idx;
          op_wr_d = wr_vld[pick_idx];
          addr_d  = i_addr[pick_idx];
          wdata_d = i_wdata[pick_idx];
          wmask_d = '0;
          if (wr_vld[pick_idx]) begin
            for (int k = 0; k < LANE_CNT; k++) begin
              wmask_d[k] = (k <= int'(i_wr_size[pick_idx]));
            end
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (i_mem_ready) begin
          state_d = op_wr_q ? DONE : RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (i_mem_rvalid) begin
          rd_data_d = i_mem_rdata;
          state_d   = DONE;
        end
      end
      DONE: begin
        // Requests are ignored here; the served proc drops its request this cycle
        rr_ptr_d = (idx_q == IDX_W'(PROC_COUNT - 1)) ? '0 : idx_q + IDX_W'(1);
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are flopped versions of what the next state implies
    mem_req_d = (state_d == ISSUE);
    busy_d    = (state_d != IDLE);
    if (state_d == DONE) begin
      if (op_wr_d) grant_wr_d[idx_d] = 1'b1;
      else         grant_rd_d[idx_d] = 1'b1;
    end
  end

  // State and output registers; reset drops any in-flight transaction
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      idx_q      <= '0;
      op_wr_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      rd_data_q  <= '0;
      mem_req_q  <= 1'b0;
      busy_q     <= 1'b0;
      grant_rd_q <= '0;
      grant_wr_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      idx_q      <= idx_d;
      op_wr_q    <= op_wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      rd_data_q  <= rd_data_d;
      mem_req_q  <= mem_req_d;
      busy_q     <= busy_d;
      grant_rd_q <= grant_rd_d;
      grant_wr_q <= grant_wr_d;
    end
  end

  assign o_grant_rd  = grant_rd_q;
  assign o_grant_wr  = grant_wr_q;
  assign o_rd_data   = rd_data_q;
  assign o_mem_req   = mem_req_q;
  assign o_mem_we    = op_wr_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_mem_wmask = wmask_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model plus directed tests.
// Inputs change on the falling edge; outputs are compared on the falling edge.
// A behavioural memory responder supplies ready stalls and delayed read data.
module tb_mem_arbiter;

  localparam int P  = 4;
  localparam int BW = 256;
  localparam int LN = 8;

  localparam int PH_BUS  = 0;
  localparam int PH_WAIT = 1;
  localparam int PH_GNT  = 2;

  logic                 i_clk = 1'b0;
  logic                 i_rstn;
  logic [P-1:0]         i_req_rd, i_req_wr, i_wr_en;
  logic [P-1:0][31:0]   i_addr;
  logic [P-1:0][BW-1:0] i_wdata;
  logic [P-1:0][2:0]    i_wr_size;
  logic [P-1:0]         o_grant_rd, o_grant_wr;
  logic [BW-1:0]        o_rd_data;
  logic                 o_mem_req, o_mem_we;
  logic [31:0]          o_mem_addr;
  logic [BW-1:0]        o_mem_wdata;
  logic [LN-1:0]        o_mem_wmask;
  logic                 i_mem_ready;
  logic [BW-1:0]        i_mem_rdata;
  logic                 i_mem_rvalid;
  logic                 o_busy;

  mem_arbiter dut (
    .i_clk        (i_clk),
    .i_rstn       (i_rstn),
    .i_req_rd     (i_req_rd),
    .i_req_wr     (i_req_wr),
    .i_wr_en      (i_wr_en),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .i_wr_size    (i_wr_size),
    .o_grant_rd   (o_grant_rd),
    .o_grant_wr   (o_grant_wr),
    .o_rd_data    (o_rd_data),
    .o_mem_req    (o_mem_req),
    .o_mem_we     (o_mem_we),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_wmask  (o_mem_wmask),
    .i_mem_ready  (i_mem_ready),
    .i_mem_rdata  (i_mem_rdata),
    .i_mem_rvalid (i_mem_rvalid),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge i_clk);
  endtask

  // Memory responder: optional ready stall, read data lat cycles after acceptance
  int            stall_cnt = 0;
  int            lat       = 1;
  int            rd_cnt    = 0;
  logic [BW-1:0] rd_dat    = '0;
  logic          extra_rv  = 1'b0;

  always @(negedge i_clk) begin
    i_mem_rvalid = extra_rv;
    if (extra_rv) i_mem_rdata = rd_dat;
    if (rd_cnt > 0) begin
      rd_cnt--;
      if (rd_cnt == 0) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = rd_dat;
      end
    end
    if (o_mem_req) begin
      if (stall_cnt > 0) begin
        i_mem_ready = 1'b0;
        stall_cnt--;
      end else begin
        i_mem_ready = 1'b1;
        if (!o_mem_we) rd_cnt = lat;
      end
    end else begin
      i_mem_ready = 1'b1;
    end
  end

  // Transaction model: one active transaction, winner scanned from the pointer
  bit            m_act;
  int            m_phase, m_proc, m_ptr;
  bit            m_wr;
  logic [31:0]   m_addr;
  logic [BW-1:0] m_data, m_rd;
  logic [LN-1:0] m_mask;

  always @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      m_act   = 0;
      m_ptr   = 0;
      m_phase = PH_BUS;
      m_rd    = '0;
    end else if (!m_act) begin
      for (int k = 0; k < P; k++) begin
        int p;
        p = (m_ptr + k) % P;
        if (!m_act && (i_req_rd[p] || (i_req_wr[p] && i_wr_en[p]))) begin
          m_act   = 1;
          m_phase = PH_BUS;
          m_proc  = p;
          m_wr    = i_req_wr[p] && i_wr_en[p];
          m_addr  = i_addr[p];
          m_data  = i_wdata[p];
          m_mask  = m_wr ? LN'((1 << (int'(i_wr_size[p]) + 1)) - 1) : '0;
        end
      end
    end else begin
      case (m_phase)
        PH_BUS:  if (i_mem_ready) m_phase = m_wr ? PH_GNT : PH_WAIT;
        PH_WAIT: if (i_mem_rvalid) begin
                   m_rd    = i_mem_rdata;
                   m_phase = PH_GNT;
                 end
        default: begin
                   m_ptr = (m_proc + 1) % P;
                   m_act = 0;
                 end
      endcase
    end
  end

  // Every-cycle comparison against the model
  always @(negedge i_clk) begin
    logic [P-1:0] eg_rd, eg_wr;
    eg_rd = '0;
    eg_wr = '0;
    if (m_act && m_phase == PH_GNT) begin
      if (m_wr) eg_wr[m_proc] = 1'b1;
      else      eg_rd[m_proc] = 1'b1;
    end
    chk("m_busy", o_busy, m_act);
    chk("m_mem_req", o_mem_req, m_act && m_phase == PH_BUS);
    chk("m_grant_rd", o_grant_rd, eg_rd);
    chk("m_grant_wr", o_grant_wr, eg_wr);
    chk("m_rd_data", o_rd_data, m_rd);
    if (m_act && m_phase == PH_BUS) begin
      chk("m_mem_we", o_mem_we, m_wr);
      chk("m_mem_addr", o_mem_addr, m_addr);
      chk("m_mem_wdata", o_mem_wdata, m_data);
      chk("m_mem_wmask", o_mem_wmask, m_mask);
    end
  end

  // Run until no valid request remains and the arbiter is idle; grants are
  // recorded as nibbles {1, wr, proc[1:0]} in arrival order.
  logic [31:0] ord_code;

  task automatic run_until_idle();
    bit done;
    done     = 0;
    ord_code = '0;
    for (int n = 0; n < 300 && !done; n++) begin
      cyc();
      for (int p = 0; p < P; p++) begin
        if (o_grant_rd[p]) begin
          ord_code  = {ord_code[27:0], 4'(8 + p)};
          i_req_rd[p] = 1'b0;
        end
        if (o_grant_wr[p]) begin
          ord_code  = {ord_code[27:0], 4'(12 + p)};
          i_req_wr[p] = 1'b0;
          i_wr_en[p]  = 1'b0;
        end
      end
      if (!o_busy && ((i_req_rd | (i_req_wr & i_wr_en)) == '0)) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL run_until_idle: still busy=%0b after 300 cycles, required idle", o_busy);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    i_rstn      = 1'b1;
    i_req_rd    = '0;
    i_req_wr    = '0;
    i_wr_en     = '0;
    i_addr      = '0;
    i_wdata     = '0;
    i_wr_size   = '0;
    i_mem_ready = 1'b1;
    i_mem_rdata = '0;
    i_mem_rvalid = 1'b0;
    #2 i_rstn = 1'b0;
    repeat (3) cyc();
    chk("rst_busy", o_busy, 0);
    chk("rst_mem_req", o_mem_req, 0);
    chk("rst_grant_rd", o_grant_rd, 0);
    chk("rst_grant_wr", o_grant_wr, 0);
    chk("rst_rd_data", o_rd_data, 0);
    chk("rst_mem_addr", o_mem_addr, 0);
    #2 i_rstn = 1'b1;
    cyc();

    // 1: proc 2 write, size 3 -> lanes 0..3
    i_addr[2]    = 32'h40;
    i_wdata[2]   = {8{32'h1111_2222}};
    i_wr_size[2] = 3'd3;
    i_wr_en[2]   = 1'b1;
    i_req_wr[2]  = 1'b1;
    cyc();
    chk("t1_req", o_mem_req, 1);
    chk("t1_we", o_mem_we, 1);
    chk("t1_wmask", o_mem_wmask, 8'h0F);
    chk("t1_addr", o_mem_addr, 32'h40);
    chk("t1_early_grant", o_grant_wr, 4'b0000);
    cyc();
    chk("t1_grant", o_grant_wr, 4'b0100);
    i_req_wr[2] = 1'b0;
    i_wr_en[2]  = 1'b0;
    cyc();
    chk("t1_grant_pulse", o_grant_wr, 4'b0000);
    chk("t1_idle", o_busy, 0);

    // 2: proc 1 read, data 3 cycles after acceptance -> grant at N+5
    lat         = 3;
    rd_dat      = {8{32'hDEAD_BEEF}};
    i_addr[1]   = 32'h80;
    i_req_rd[1] = 1'b1;
    cyc();
    chk("t2_req", o_mem_req, 1);
    chk("t2_we", o_mem_we, 0);
    chk("t2_addr", o_mem_addr, 32'h80);
    chk("t2_wmask", o_mem_wmask, 8'h00);
    repeat (3) begin
      cyc();
      chk("t2_nogrant", o_grant_rd, 4'b0000);
    end
    cyc();
    chk("t2_grant", o_grant_rd, 4'b0010);
    chk("t2_data", o_rd_data, {8{32'hDEAD_BEEF}});
    i_req_rd[1] = 1'b0;
    cyc();
    chk("t2_grant_pulse", o_grant_rd, 4'b0000);

    // 3: pointer back to 0, all procs read -> 0,1,2,3; then 0,1 -> 0 first
    #2 i_rstn = 1'b0;
    cyc();
    #2 i_rstn = 1'b1;
    cyc();
    lat    = 2;
    rd_dat = {8{32'hA5A5_0003}};
    for (int p = 0; p < P; p++) i_addr[p] = 32'h1000 + 32'(p * 32);
    i_req_rd = 4'b1111;
    run_until_idle();
    chk("t3_order_all", ord_code, 32'h0000_89AB);
    chk("t3_rd_data", o_rd_data, {8{32'hA5A5_0003}});
    i_req_rd = 4'b0011;
    run_until_idle();
    chk("t3_order_wrap", ord_code, 32'h0000_0089);

    // 4: proc 3 read+write -> write then read; proc 0 write without enable never served
    lat          = 1;
    rd_dat       = {8{32'h0BAD_F00D}};
    i_addr[3]    = 32'h300;
    i_wdata[3]   = {8{32'h3333_0000}};
    i_wr_size[3] = 3'd0;
    i_wr_en[3]   = 1'b1;
    i_req_wr[3]  = 1'b1;
    i_req_rd[3]  = 1'b1;
    i_req_wr[0]  = 1'b1;
    i_wr_en[0]   = 1'b0;
    run_until_idle();
    chk("t4_order", ord_code, 32'h0000_00FB);
    i_req_wr[0] = 1'b0;

    // 5: ready low for 5 ISSUE cycles, full-width write from proc 0
    stall_cnt    = 5;
    i_addr[0]    = 32'h100;
    i_wdata[0]   = {8{32'hCAFE_0000}};
    i_wr_size[0] = 3'd7;
    i_wr_en[0]   = 1'b1;
    i_req_wr[0]  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t5_req_held", o_mem_req, 1);
      chk("t5_addr_held", o_mem_addr, 32'h100);
      chk("t5_wdata_held", o_mem_wdata, {8{32'hCAFE_0000}});
      chk("t5_wmask", o_mem_wmask, 8'hFF);
      chk("t5_nogrant", o_grant_wr, 4'b0000);
    end
    cyc();
    chk("t5_grant", o_grant_wr, 4'b0001);
    chk("t5_req_dropped", o_mem_req, 0);
    i_req_wr[0] = 1'b0;
    i_wr_en[0]  = 1'b0;
    cyc();

    // 6: reset while waiting for read data, rvalid during and after reset
    lat         = 20;
    rd_dat      = {8{32'h6666_7777}};
    i_addr[2]   = 32'h200;
    i_req_rd[2] = 1'b1;
    repeat (3) cyc();
    chk("t6_busy_wait", o_busy, 1);
    #2 i_rstn = 1'b0;
    extra_rv = 1'b1;
    cyc();
    chk("t6_rst_busy", o_busy, 0);
    chk("t6_rst_req", o_mem_req, 0);
    chk("t6_rst_we", o_mem_we, 0);
    chk("t6_rst_addr", o_mem_addr, 0);
    chk("t6_rst_wdata", o_mem_wdata, 0);
    chk("t6_rst_wmask", o_mem_wmask, 0);
    chk("t6_rst_grant", {o_grant_rd, o_grant_wr}, 8'h00);
    chk("t6_rst_rd_data", o_rd_data, 0);
    #2;
    extra_rv    = 1'b0;
    i_req_rd[2] = 1'b0;
    i_rstn      = 1'b1;
    repeat (25) begin
      cyc();
      chk("t6_no_late_grant", {o_grant_rd, o_grant_wr}, 8'h00);
      chk("t6_idle", o_busy, 0);
    end
    chk("t6_rd_data_kept", o_rd_data, 0);
    lat         = 1;
    rd_dat      = {8{32'h1357_9BDF}};
    i_req_rd[0] = 1'b1;
    i_req_rd[3] = 1'b1;
    run_until_idle();
    chk("t6_ptr_reset_order", ord_code, 32'h0000_008B);
    chk("t6_rd_data", o_rd_data, {8{32'h1357_9BDF}});

    repeat (2) cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shared-memory arbiter and port multiplexer between the processor pool and the single data-memory port. It collects per-processor read/write requests and arbitrates round-robin. It issues one memory transaction at a time, returns grants to the pool, and broadcasts read data on the pool's shared input bus. Write-size codes become a lane write mask.

Parameters:
PROC_COUNT, `PROC_COUNT (4), number of requesting processors
BUS_W, `BUS_W (256), data bus width in bits
WORD_W, 32, lane width; LANES = BUS_W/WORD_W (8)
ADDR_W, 32, width of addr_t

Ports:
i_clk  in  1  clock
i_rstn  in  1  reset, asynchronous, active-low
i_req_rd  in  PROC_COUNT  per-proc read request, held until granted
i_req_wr  in  PROC_COUNT  per-proc write request, held until granted
i_wr_en  in  PROC_COUNT  qualifies i_req_wr
i_addr  in  PROC_COUNT x ADDR_W  per-proc address (addr_t array)
i_wdata  in  PROC_COUNT x BUS_W  per-proc write data
i_wr_size  in  PROC_COUNT x 3  per-proc write size code
o_grant_rd  out  PROC_COUNT  one-hot, one-cycle pulse, o_rd_data valid for that proc
o_grant_wr  out  PROC_COUNT  one-hot, one-cycle pulse, write completed
o_rd_data  out  BUS_W  read data broadcast to the pool
o_mem_req  out  1  memory transaction valid
o_mem_we  out  1  1=write, 0=read
o_mem_addr  out  ADDR_W  memory address
o_mem_wdata  out  BUS_W  memory write data
o_mem_wmask  out  LANES  lane write enables
i_mem_ready  in  1  memory accepts transaction this cycle
i_mem_rdata  in  BUS_W  memory read data
i_mem_rvalid  in  1  read data valid
o_busy  out  1  state != IDLE

Behaviour:
- Reset (async, i_rstn=0): state=IDLE, rr_ptr=0, every output 0 (grants, o_rd_data, all o_mem_*, o_busy). A transaction in flight is dropped; a late i_mem_rvalid after reset is ignored (state is not RD_WAIT).
- Valid request of proc i: i_req_rd[i] | (i_req_wr[i] & i_wr_en[i]). A req_wr without wr_en counts as no write request.
- FSM states: IDLE, ISSUE, RD_WAIT, DONE. All outputs are registered.
- IDLE:
  - If no valid request, stay in IDLE.
  - Otherwise pick the winner: the first requesting proc scanning from rr_ptr upward, wrapping mod PROC_COUNT.
  - Op for the winner: write if its write request is valid, else read. A write takes priority within the same proc.
  - Latch idx, op, addr, wdata. If write, wmask[k] = (k <= wr_size) for k < LANES. If read, wmask = 0.
  - Next state is ISSUE.
- ISSUE:
  - o_mem_req=1 and o_mem_we/addr/wdata/wmask come from the latched values. Hold them stable until i_mem_ready=1.
  - On ready: write goes to DONE; read goes to RD_WAIT. o_mem_req drops in the next cycle.
  - i_mem_rvalid in ISSUE is ignored.
- RD_WAIT:
  - Wait any number of cycles for i_mem_rvalid.
  - On rvalid: o_rd_data <= i_mem_rdata, then go to DONE.
- DONE (exactly one cycle):
  - Assert o_grant_rd[idx] or o_grant_wr[idx]. rr_ptr <= (idx+1) mod PROC_COUNT. All requests are ignored this cycle.
  - Next state is IDLE. The proc drops its request at the end of DONE, so IDLE never re-serves a stale request.
- o_rd_data holds its value until the next read completes.
- Latency with ready=1:
  - Write: request seen in IDLE at cycle N, then ISSUE at N+1, grant at N+2.
  - Read with memory latency L after acceptance: grant at N+2+L.
- Proc requesting both read and write: the write is served first, the read on a later arbitration round.
- Only one transaction is ever outstanding.
- Requests changing while not in IDLE have no effect.

Decomposition:
- Shared package (defines.sv / pkg): addr_t, LANES, WORD_W, and an arb_state_t enum {IDLE, ISSUE, RD_WAIT, DONE}.
- One sub-module, rr_pick: combinational round-robin priority picker.
  - Inputs: req[PROC_COUNT], ptr.
  - Outputs: gnt_idx, any.

Test Plan:
1. Proc 2 write, addr 0x40, wr_size 3, ready=1 -> o_mem_req with we=1, wmask=8'h0F at cycle N+1; o_grant_wr=4'b0100 at N+2 for 1 cycle.
2. Proc 1 read, addr 0x80, memory rvalid 3 cycles after accept with data 0xDEAD... -> o_grant_rd=4'b0010 and o_rd_data=0xDEAD... in the same cycle, N+5.
3. All 4 procs request reads, rr_ptr=0 -> grants in order 0,1,2,3; then proc 0 and 1 re-request -> 0 served first (ptr wrapped to 0).
4. Proc 3 asserts req_rd and req_wr together -> write granted first, read on the next round; req_wr with wr_en=0 -> never granted.
5. i_mem_ready held 0 for 5 cycles in ISSUE -> o_mem_req/addr/wdata stable for all 5 cycles, grant only after ready.
6. Reset asserted in RD_WAIT, rvalid pulsed during reset -> all outputs 0, no grant, rr_ptr=0, state IDLE after release.
